grid_verifier: RTL and testbench
================================

// Module: grid_verifier
// PURPOSE
//  Downstream checker for the grid generator. After the generator reports done/success, its read-out streams
//  the finished grid in row-major order. This block tests every cell against the one-hot, row, column and
//  block rules, then reports pass/fail and the first cell that broke a rule. It is used in benches and in
//  on-chip self-test.
// PARAMETERS
//  ORDER  3                block side; LEN = ORDER*ORDER symbols, AREA = LEN*LEN cells (from grid_dimensions.svh)
//  ROW_W  $clog2(LEN)      width of the row/column index outputs
// PORTS
//  clock      in   1      single clock; all state changes on its rising edge
//  reset_n    in   1      asynchronous assert, active-low; release is synchronous to clock upstream
//  start      in   1      one-cycle pulse; starts a check; ignored unless in IDLE or DONE
//  in_valid   in   1      cell value is valid
//  in_ready   out  1      block accepts the cell; high only in CHECK
//  in_value   in   LEN    cell value, one-hot (bit k means symbol k+1)
//  busy       out  1      high while in CHECK
//  done       out  1      one-cycle pulse when the last cell has been accepted
//  pass       out  1      result of the last check; held until the next start
//  err_row    out  ROW_W  row of the first bad cell; held
//  err_col    out  ROW_W  column of the first bad cell; held
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): state=IDLE; in_ready, busy, done and pass are 0; err_row/err_col are 0;
//    all masks and counters are 0.
//  - States and transitions:
//      IDLE  -start->  CHECK
//      CHECK -last cell accepted->  DONE
//      DONE  -start->  CHECK
//    Entering CHECK clears all masks, both counters and the error flag.
//  - Handshake: a cell is accepted when in_valid && in_ready. There is no backpressure inside CHECK, so
//    in_ready = (state==CHECK). in_value is sampled on the accepting edge only.
//  - Tracking: cursor (row, col) starts at (0,0) and col increments per accepted cell. When col=LEN-1,
//    col wraps to 0 and row increments. The cell accepted with row=LEN-1, col=LEN-1 is the last cell.
//  - Masks:
//      row_mask  LEN bits; cleared when col wraps
//      col_mask  LEN x LEN bits, one per column
//      blk_mask  ORDER x LEN bits, one per block in the current block-row; cleared when row wraps to a
//                multiple of ORDER
//  - A cell is bad if any of these holds:
//      popcount(in_value) != 1 (zero or several bits set)
//      in_value & row_mask != 0
//      in_value & col_mask[col] != 0
//      in_value & blk_mask[col/ORDER] != 0
//    Every accepted cell's value is ORed into all three masks, whether or not it is bad.
//  - First error: on the first bad cell, latch err_row/err_col and set the error flag. Later bad cells do not
//    change them. The check continues to consume all AREA cells so the upstream read-out always completes.
//  - Completion: on the edge that accepts the last cell, go to DONE. done=1 for exactly the next cycle and
//    pass = !error. The error flag includes the last cell's own result.
//  - Latency: done rises 1 cycle after the last accepting edge. Total time is at least AREA+1 cycles from
//    start.
//  - Edge cases:
//      start while in CHECK: ignored; no restart.
//      start in the same cycle as done: accepted; the new check starts; pass and err_* keep the previous
//        result until the new done.
//      in_valid outside CHECK: ignored; nothing is accepted.
//      reset_n asserted mid-check: everything goes to reset values at once and the partial result is lost.
//  - Width rules:
//      col/ORDER is computed with a constant divider, which is a small LUT for ORDER up to 4.
//      The popcount check is done as onehot = |v && !(v & (v-1)).
// STRUCTURE
//  - Shared package grid_pkg:
//      localparams LEN, AREA, ROW_W
//      typedef logic [LEN-1:0] value_t
//      typedef logic [ROW_W-1:0] idx_t
//      verifier state enum {IDLE, CHECK, DONE}
//  - Sub-module grid_verifier_cursor:
//      row/col counters, wrap flags, last-cell flag and block-column index
//      resets on start or reset_n
//  - Everything else stays flat: the mask arrays and the FSM live in grid_verifier.
// TESTING
//  - Valid solved 9x9 grid, in_valid held high -> in_ready high for 81 cycles, then done pulse; pass=1; err=(0,0).
//  - Same grid with cell (4,7) set to 0 -> pass=0, err_row=4, err_col=7.
//  - Swap two symbols within row 2 only, which breaks columns -> pass=0; err points at the first column repeat
//    in row-major order.
//  - Grid with valid rows and columns but a bad block, from a cyclic shift by 1 per row -> pass=0, err at (1,0).
//  - Random in_valid gaps (about 30% idle) on the valid grid -> same result; done exactly 1 cycle after the
//    81st accept.
//  - reset_n pulsed low after 40 cells -> all outputs 0 at once. A new start then gives a full 81-cell check
//    with pass=1.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared dimensions, types and helpers for the grid generator/verifier slice.
package grid_pkg;

   localparam int unsigned ORDER = 3;
   localparam int unsigned LEN   = ORDER * ORDER;
   localparam int unsigned AREA  = LEN * LEN;
   localparam int unsigned ROW_W = $clog2(LEN);
   localparam int unsigned BLK_W = (ORDER > 1) ? $clog2(ORDER) : 1;

   typedef logic [LEN-1:0]   value_t;
   typedef logic [ROW_W-1:0] idx_t;
   typedef logic [BLK_W-1:0] blk_t;

   typedef enum logic [1:0] {IDLE, CHECK, DONE} vstate_t;

   // Constant divisor, so this folds into a small lookup.
   function automatic blk_t blk_of(input idx_t col);
      return blk_t'(col / idx_t'(ORDER));
   endfunction

   function automatic logic is_onehot(input value_t v);
      return (|v) && !(|(v & (v - value_t'(1))));
   endfunction

endpackage

// File: rtl/grid_verifier_cursor.sv
// Row-major cell cursor for the verifier: row/col counters plus the wrap,
// last-cell and block-column flags derived from them.
module grid_verifier_cursor
   import grid_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic advance,
   output idx_t row,
   output idx_t col,
   output logic col_wrap,
   output logic blk_wrap,
   output logic last,
   output blk_t blk_col
);

   always_comb begin
      col_wrap = (col == idx_t'(LEN - 1));
      last     = col_wrap && (row == idx_t'(LEN - 1));
      // The row about to finish is the bottom row of a block-row.
      blk_wrap = col_wrap && ((row % idx_t'(ORDER)) == idx_t'(ORDER - 1));
      blk_col  = blk_of(col);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col_wrap) begin
            col <= '0;
            row <= last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/grid_verifier.sv
// Checks a streamed, row-major grid against the one-hot, row, column and block
// rules; reports pass/fail and the first offending cell.
module grid_verifier
   import grid_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LEN-1:0]   in_value,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ROW_W-1:0] err_row,
   output logic [ROW_W-1:0] err_col
);

   vstate_t state, state_nx;
   value_t  row_mask;
   value_t  col_mask [LEN];
   value_t  blk_mask [ORDER];
   logic    err_flag;
   idx_t    first_row, first_col;
   idx_t    row, col;
   blk_t    blk_col;
   logic    col_wrap, blk_wrap, last;
   logic    clear, accept, bad;

   assign clear  = start && (state != CHECK);
   assign accept = in_valid && in_ready;

   grid_verifier_cursor u_cursor (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (clear),
      .advance  (accept),
      .row      (row),
      .col      (col),
      .col_wrap (col_wrap),
      .blk_wrap (blk_wrap),
      .last     (last),
      .blk_col  (blk_col)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      bad      = 1'b0;
      case (state)
         IDLE:    if (start) state_nx = CHECK;
         CHECK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && last) state_nx = DONE;
         end
         DONE:    if (start) state_nx = CHECK;
         default: state_nx = IDLE;
      endcase
      bad = !is_onehot(in_value)
            || (|(in_value & row_mask))
            || (|(in_value & col_mask[col]))
            || (|(in_value & blk_mask[blk_col]));
   end

   // err_row/err_col/pass only move at done, so a restart keeps the previous result visible.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row_mask  <= '0;
         for (int unsigned i = 0; i < LEN; i++)   col_mask[i] <= '0;
         for (int unsigned i = 0; i < ORDER; i++) blk_mask[i] <= '0;
         err_flag  <= 1'b0;
         first_row <= '0;
         first_col <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_row   <= '0;
         err_col   <= '0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            row_mask  <= '0;
            for (int unsigned i = 0; i < LEN; i++)   col_mask[i] <= '0;
            for (int unsigned i = 0; i < ORDER; i++) blk_mask[i] <= '0;
            err_flag  <= 1'b0;
            first_row <= '0;
            first_col <= '0;
         end else if (accept) begin
            row_mask      <= col_wrap ? '0 : (row_mask | in_value);
            col_mask[col] <= col_mask[col] | in_value;
            if (blk_wrap) begin
               for (int unsigned i = 0; i < ORDER; i++) blk_mask[i] <= '0;
            end else begin
               blk_mask[blk_col] <= blk_mask[blk_col] | in_value;
            end
            if (bad && !err_flag) begin
               err_flag  <= 1'b1;
               first_row <= row;
               first_col <= col;
            end
            if (last) begin
               done    <= 1'b1;
               pass    <= !(err_flag || bad);
               err_row <= (!err_flag && bad) ? row : first_row;
               err_col <= (!err_flag && bad) ? col : first_col;
            end
         end
      end
   end

endmodule

// File: tb/tb_grid_verifier.sv
// Directed bench for grid_verifier: table of whole-grid checks plus
// hand-written sequences for restart, reset and ignored-input corners.
module tb_grid_verifier;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_value;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_row;
   logic [3:0] err_col;

   int checks   = 0;
   int failures = 0;

   grid_verifier dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_row  (err_row),
      .err_col  (err_col)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    kind;
      bit    gaps;
      bit    exp_pass;
      int    exp_row;
      int    exp_col;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Grid kinds: 0 valid, 1 valid with (4,7) empty, 2 row 2 cols 0/1 swapped, 3 cyclic shift.
   function automatic int cell_sym(input int kind, input int r, input int c);
      int base;
      base = (r * 3 + r / 3 + c) % 9;
      case (kind)
         1: return (r == 4 && c == 7) ? -1 : base;
         2: begin
            if (r == 2 && c == 0) return (2 * 3 + 0 + 1) % 9;
            if (r == 2 && c == 1) return (2 * 3 + 0 + 0) % 9;
            return base;
         end
         3: return (r + c) % 9;
         default: return base;
      endcase
   endfunction

   function automatic logic [8:0] sym(input int s);
      logic [8:0] v;
      v = '0;
      if (s >= 0) v[s] = 1'b1;
      return v;
   endfunction

   task automatic do_start(input string name);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({name, ".busy_after_start"}, busy, 1);
   endtask

   // Called at a negedge with the DUT in CHECK; returns at the negedge after the last accept.
   task automatic feed(input string name, input int kind, input bit gaps,
                       input int n_cells, input int start_at);
      int  idx, cyc, ready_low, early_done;
      bit  v, rdy;
      idx = 0; cyc = 0; ready_low = 0; early_done = 0;
      while (idx < n_cells && cyc < 400) begin
         v = gaps ? ($urandom_range(0, 9) >= 3) : 1'b1;
         in_valid = v;
         in_value = sym(cell_sym(kind, idx / 9, idx % 9));
         if (cyc == start_at) start = 1'b1;
         rdy = in_ready;
         if (!rdy) ready_low++;
         if (done) early_done++;
         @(posedge clock);
         if (v && rdy) idx++;
         cyc++;
         @(negedge clock);
         start = 1'b0;
      end
      in_valid = 1'b0;
      check({name, ".cells_accepted"}, idx, n_cells);
      check({name, ".ready_low"}, ready_low, 0);
      check({name, ".early_done"}, early_done, 0);
      if (!gaps) check({name, ".cycles"}, cyc, n_cells);
   endtask

   task automatic check_result(input string name, input bit exp_pass, input int er, input int ec);
      check({name, ".done"}, done, 1);
      check({name, ".pass"}, pass, exp_pass);
      check({name, ".err_row"}, err_row, er);
      check({name, ".err_col"}, err_col, ec);
      check({name, ".busy_in_done"}, busy, 0);
      @(negedge clock);
      check({name, ".done_one_cycle"}, done, 0);
      check({name, ".pass_held"}, pass, exp_pass);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      vecs[0] = '{"valid",      0, 1'b0, 1'b1, 0, 0};
      vecs[1] = '{"empty_4_7",  1, 1'b0, 1'b0, 4, 7};
      vecs[2] = '{"row2_swap",  2, 1'b0, 1'b0, 5, 0};
      vecs[3] = '{"cyclic",     3, 1'b0, 1'b0, 1, 0};
      vecs[4] = '{"swap_gaps",  2, 1'b1, 1'b0, 5, 0};
      vecs[5] = '{"valid_gaps", 0, 1'b1, 1'b1, 0, 0};

      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      repeat (2) @(negedge clock);
      check("reset.in_ready", in_ready, 0);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.pass", pass, 0);
      check("reset.err_row", err_row, 0);
      check("reset.err_col", err_col, 0);
      reset_n = 1'b1;

      // in_valid in IDLE with a duplicate-making value must not be consumed.
      in_valid = 1'b1;
      in_value = sym(0);
      repeat (3) begin
         @(negedge clock);
         check("idle.in_ready", in_ready, 0);
      end
      in_valid = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_start(vecs[i].name);
         feed(vecs[i].name, vecs[i].kind, vecs[i].gaps, 81, -1);
         check_result(vecs[i].name, vecs[i].exp_pass, vecs[i].exp_row, vecs[i].exp_col);
      end

      // start pulsed mid-check must not restart the cursor.
      do_start("start_in_check");
      feed("start_in_check", 0, 1'b0, 81, 20);
      check_result("start_in_check", 1'b1, 0, 0);

      // Asynchronous reset after 40 cells.
      do_start("mid_reset");
      feed("mid_reset", 0, 1'b0, 40, -1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_reset.in_ready", in_ready, 0);
      check("mid_reset.busy", busy, 0);
      check("mid_reset.done", done, 0);
      check("mid_reset.pass", pass, 0);
      check("mid_reset.err_row", err_row, 0);
      check("mid_reset.err_col", err_col, 0);
      @(negedge clock);
      reset_n = 1'b1;
      do_start("after_reset");
      feed("after_reset", 0, 1'b0, 81, -1);
      check_result("after_reset", 1'b1, 0, 0);

      // start coincident with done: new check begins, old result held until new done.
      do_start("restart_a");
      feed("restart_a", 1, 1'b0, 81, -1);
      check("restart_a.done", done, 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("restart_b.busy", busy, 1);
      check("restart_b.in_ready", in_ready, 1);
      check("restart_b.done", done, 0);
      check("restart_b.pass_kept", pass, 0);
      check("restart_b.err_row_kept", err_row, 4);
      check("restart_b.err_col_kept", err_col, 7);
      feed("restart_b", 0, 1'b0, 81, -1);
      check_result("restart_b", 1'b1, 0, 0);

      // in_valid while in DONE is ignored.
      in_valid = 1'b1;
      in_value = 9'h1FF;
      repeat (3) begin
         @(negedge clock);
         check("done_state.in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      check("done_state.pass_held", pass, 1);
      do_start("after_done_valid");
      feed("after_done_valid", 3, 1'b0, 81, -1);
      check_result("after_done_valid", 1'b0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
